// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared state encoding and default timing constants for the trigger scheduler
package sync_pkg;

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        WAIT_OPTO       = 3'd1,
        WAIT_OPEN       = 3'd2,
        TRIGGER_PROLONG = 3'd3,
        HOLDOFF_ST      = 3'd4
    } state_t;

    localparam int FG_DELAY_DEFAULT    = 400_000;
    localparam int TRIGGER_LEN_DEFAULT = 100;
    localparam int OPTO_TIMEOUT        = 1_000_000;
    localparam int HOLDOFF             = 1000;

endpackage

// File: rtl/sync_rr_arbiter.sv
// rtl/sync_rr_arbiter.sv - combinational round-robin pick starting after the last granted index
module sync_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    // First pass covers indices above the pointer, second pass wraps around to the rest.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && req[i] && (i > int'(last))) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && req[i] && (i <= int'(last))) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_trigger_scheduler.sv
// rtl/sync_trigger_scheduler.sv - shared frame-grabber trigger sequencer with round-robin requesters
module sync_trigger_scheduler #(
    parameter int N_REQ               = 4,
    parameter int CNT_W               = 32,
    parameter int FG_DELAY_DEFAULT    = sync_pkg::FG_DELAY_DEFAULT,
    parameter int TRIGGER_LEN_DEFAULT = sync_pkg::TRIGGER_LEN_DEFAULT,
    parameter int OPTO_TIMEOUT        = sync_pkg::OPTO_TIMEOUT,
    parameter int HOLDOFF             = sync_pkg::HOLDOFF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     abort,
    input  logic                     fg_signal,
    input  logic                     cfg_wr,
    input  logic [$clog2(N_REQ)-1:0] cfg_sel,
    input  logic [CNT_W-1:0]         cfg_delay,
    input  logic [CNT_W-1:0]         cfg_len,
    output logic [N_REQ-1:0]         grant,
    output logic                     output_trigger,
    output logic                     done,
    output logic                     timeout,
    output logic                     busy,
    output logic [2:0]               scenario_state
);
    import sync_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(OPTO_TIMEOUT);
    localparam logic [CNT_W:0] HO_LIM = (CNT_W+1)'(HOLDOFF);
    localparam logic [CNT_W:0] ONE    = (CNT_W+1)'(1);

    state_t state, state_n;

    logic [CNT_W-1:0] delay_reg [N_REQ];
    logic [CNT_W-1:0] len_reg   [N_REQ];
    logic [CNT_W-1:0] work_delay, work_len, cnt, cnt_n;
    logic [CNT_W:0]   cnt_p1;
    logic [IDX_W-1:0] last, win_idx;
    logic [N_REQ-1:0] arb_winner, grant_n;
    logic             arb_valid, latch, trig_n, done_n, timeout_n, do_abort;
    logic             fg_s1, fg_s2, fg_s3, opto_rise;

    sync_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req    (req),
        .last   (last),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_winner[i]) win_idx = IDX_W'(i);
        end
    end

    // Two-stage synchronizer plus a registered rise pulse; only a fresh 0->1 transition counts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fg_s1     <= 1'b0;
            fg_s2     <= 1'b0;
            fg_s3     <= 1'b0;
            opto_rise <= 1'b0;
        end else begin
            fg_s1     <= fg_signal;
            fg_s2     <= fg_s1;
            fg_s3     <= fg_s2;
            opto_rise <= fg_s2 & ~fg_s3;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                delay_reg[i] <= CNT_W'(FG_DELAY_DEFAULT);
                len_reg[i]   <= CNT_W'(TRIGGER_LEN_DEFAULT);
            end
        end else if (cfg_wr && (int'(cfg_sel) < N_REQ)) begin
            delay_reg[cfg_sel] <= cfg_delay;
            len_reg[cfg_sel]   <= cfg_len;
        end
    end

    assign cnt_p1   = {1'b0, cnt} + ONE;
    assign do_abort = abort && ((state == WAIT_OPTO) || (state == WAIT_OPEN) ||
                                (state == TRIGGER_PROLONG));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt_p1[CNT_W-1:0];
        grant_n   = grant;
        trig_n    = output_trigger;
        done_n    = 1'b0;
        timeout_n = 1'b0;
        latch     = 1'b0;
        if (do_abort) begin
            state_n = HOLDOFF_ST;
            cnt_n   = '0;
            grant_n = '0;
            trig_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n   = '0;
                    grant_n = '0;
                    trig_n  = 1'b0;
                    if (arb_valid) begin
                        state_n = WAIT_OPTO;
                        grant_n = arb_winner;
                        latch   = 1'b1;
                    end
                end
                WAIT_OPTO: begin
                    // The opto edge is checked before the timeout so it wins a tie.
                    if (opto_rise) begin
                        cnt_n = '0;
                        if (work_delay != '0) begin
                            state_n = WAIT_OPEN;
                        end else begin
                            state_n = TRIGGER_PROLONG;
                            trig_n  = 1'b1;
                        end
                    end else if (cnt_p1 >= TO_LIM) begin
                        state_n   = HOLDOFF_ST;
                        cnt_n     = '0;
                        grant_n   = '0;
                        timeout_n = 1'b1;
                    end
                end
                WAIT_OPEN: begin
                    if (cnt_p1 >= {1'b0, work_delay}) begin
                        state_n = TRIGGER_PROLONG;
                        cnt_n   = '0;
                        trig_n  = 1'b1;
                    end
                end
                TRIGGER_PROLONG: begin
                    if (cnt_p1 >= {1'b0, work_len}) begin
                        state_n = HOLDOFF_ST;
                        cnt_n   = '0;
                        grant_n = '0;
                        trig_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
                HOLDOFF_ST: begin
                    if (cnt_p1 >= HO_LIM) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    grant_n = '0;
                    trig_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= IDX_W'(N_REQ - 1);
            work_delay     <= '0;
            work_len       <= '0;
            grant          <= '0;
            output_trigger <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            grant          <= grant_n;
            output_trigger <= trig_n;
            done           <= done_n;
            timeout        <= timeout_n;
            busy           <= (state_n != IDLE);
            if (latch) begin
                last       <= win_idx;
                work_delay <= delay_reg[win_idx];
                work_len   <= (len_reg[win_idx] == '0) ? CNT_W'(1) : len_reg[win_idx];
            end
        end
    end

    assign scenario_state = state;

endmodule

// File: tb/tb_sync_trigger_scheduler.sv
// tb/tb_sync_trigger_scheduler.sv - directed self-checking bench for sync_trigger_scheduler
module tb_sync_trigger_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic        abort;
    logic        fg_signal;
    logic        cfg_wr;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_delay;
    logic [31:0] cfg_len;
    logic [3:0]  grant;
    logic        output_trigger, done, timeout, busy;
    logic [2:0]  scenario_state;

    int checks = 0;
    int errors = 0;
    int n;

    sync_trigger_scheduler #(
        .N_REQ(4), .CNT_W(32), .FG_DELAY_DEFAULT(40), .TRIGGER_LEN_DEFAULT(10),
        .OPTO_TIMEOUT(50), .HOLDOFF(20)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .abort(abort), .fg_signal(fg_signal),
        .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_delay(cfg_delay), .cfg_len(cfg_len),
        .grant(grant), .output_trigger(output_trigger), .done(done), .timeout(timeout),
        .busy(busy), .scenario_state(scenario_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_val(input int sig);
        case (sig)
            0:       return output_trigger;
            1:       return done;
            2:       return timeout;
            3:       return |grant;
            4:       return busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cycles_until(input int sig, input logic val, input int max, output int cnt);
        cnt = 0;
        while (sig_val(sig) !== val && cnt < max) begin
            tick();
            cnt++;
        end
        if (sig_val(sig) !== val) cnt = -1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] d, input logic [31:0] l);
        cfg_wr = 1'b1; cfg_sel = sel; cfg_delay = d; cfg_len = l;
        tick();
        cfg_wr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; req = '0; abort = 1'b0; fg_signal = 1'b0;
        cfg_wr = 1'b0; cfg_sel = '0; cfg_delay = '0; cfg_len = '0;
        tick(); tick();
        chk("rst_grant", grant, 0);
        chk("rst_trig", output_trigger, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", scenario_state, 0);
        chk("rst_done_to", {done, timeout}, 0);
        reset_n = 1'b1;
        tick();

        // Default delay/length shot on requester 0
        req = 4'b0001;
        tick();
        chk("def_grant", grant, 4'b0001);
        chk("def_busy", busy, 1);
        chk("def_state", scenario_state, 1);
        req = '0;
        fg_signal = 1'b1;
        tick(); tick(); tick();
        chk("def_state_k2", scenario_state, 1);
        tick();
        chk("def_state_k3", scenario_state, 2);
        cycles_until(0, 1'b1, 100, n);
        chk("def_delay", n, 40);
        cycles_until(0, 1'b0, 100, n);
        chk("def_len", n, 10);
        chk("def_done", done, 1);
        chk("def_grant_drop", grant, 0);
        chk("def_holdoff", scenario_state, 4);
        fg_signal = 1'b0;
        cycles_until(4, 1'b0, 100, n);
        chk("def_holdoff_len", n, 20);
        chk("def_done_once", done, 0);

        // Round robin after a fresh reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) cfg_write(2'(i), 32'd2, 32'd3);
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant", grant, 4'b0001 << (i % 4));
            fg_signal = 1'b1;
            cycles_until(0, 1'b1, 30, n);
            chk("rr_delay", n, 6);
            cycles_until(0, 1'b0, 30, n);
            chk("rr_len", n, 3);
            fg_signal = 1'b0;
            if (i < 4) begin
                cycles_until(3, 1'b1, 60, n);
                chk("rr_spacing", n, 21);
            end
        end
        req = '0;
        cycles_until(4, 1'b0, 60, n);
        chk("rr_idle", n, 20);

        // Zero delay and zero length on requester 2
        cfg_write(2'd2, 32'd0, 32'd0);
        req = 4'b0100;
        tick();
        chk("cfg_grant", grant, 4'b0100);
        req = '0;
        fg_signal = 1'b1;
        tick(); tick(); tick();
        chk("cfg_trig_pre", output_trigger, 0);
        tick();
        chk("cfg_trig_rise", output_trigger, 1);
        chk("cfg_state_prolong", scenario_state, 3);
        tick();
        chk("cfg_trig_fall", output_trigger, 0);
        chk("cfg_done", done, 1);
        fg_signal = 1'b0;
        cycles_until(4, 1'b0, 60, n);

        // Opto timeout with fg low, then with fg already high
        req = 4'b0010;
        tick();
        chk("to_grant", grant, 4'b0010);
        req = '0;
        cycles_until(2, 1'b1, 100, n);
        chk("to_low_cycles", n, 50);
        chk("to_trig", output_trigger, 0);
        chk("to_done", done, 0);
        chk("to_grant_drop", grant, 0);
        chk("to_state", scenario_state, 4);
        cycles_until(4, 1'b0, 60, n);
        fg_signal = 1'b1;
        tick(); tick(); tick();
        req = 4'b0010;
        tick();
        req = '0;
        cycles_until(2, 1'b1, 100, n);
        chk("to_high_cycles", n, 50);
        fg_signal = 1'b0;
        cycles_until(4, 1'b0, 60, n);

        // Abort during the trigger pulse, then abort while idle
        cfg_write(2'd3, 32'd1, 32'd100);
        req = 4'b1000;
        tick();
        chk("ab_grant", grant, 4'b1000);
        req = '0;
        fg_signal = 1'b1;
        cycles_until(0, 1'b1, 30, n);
        chk("ab_delay", n, 5);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_trig", output_trigger, 0);
        chk("ab_done", done, 0);
        chk("ab_grant_drop", grant, 0);
        chk("ab_state", scenario_state, 4);
        fg_signal = 1'b0;
        cycles_until(4, 1'b0, 60, n);
        chk("ab_holdoff_len", n, 20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle_state", scenario_state, 0);
        chk("ab_idle_busy", busy, 0);

        // Asynchronous reset during WAIT_OPEN
        cfg_write(2'd1, 32'd30, 32'd3);
        req = 4'b0010;
        tick();
        chk("rm_grant", grant, 4'b0010);
        req = '0;
        fg_signal = 1'b1;
        tick(); tick(); tick(); tick();
        chk("rm_state_open", scenario_state, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_async_grant", grant, 0);
        chk("rm_async_busy", busy, 0);
        chk("rm_async_state", scenario_state, 0);
        chk("rm_async_trig", output_trigger, 0);
        fg_signal = 1'b0;
        tick();
        reset_n = 1'b1;
        req = 4'b1111;
        tick();
        chk("rm_priority", grant, 4'b0001);
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
